// File: rtl/alu_muldiv.sv
// alu_muldiv: sequential execute-stage ALU with the base integer op set plus the
// RV32M multiply/divide family. Base ops and divide fast paths complete one
// cycle after accept; full multiply/divide run XLEN radix-2 iterations followed
// by a sign/half-select FIX cycle. valid/ready handshakes on both sides, with a
// synchronous flush that abandons anything accepted or in flight.
module alu_muldiv #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            mext,
    input  logic [2:0]      funct,
    input  logic [3:0]      alu_cntl,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [XLEN-1:0]   ZERO_X  = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   ONES_X  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   MIN_X   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] ZERO_2X = {(2*XLEN){1'b0}};
    localparam logic [SHW-1:0]    CNT_TOP = SHW'(XLEN-1);
    localparam logic [SHW-1:0]    CNT_ONE = SHW'(1);
    localparam logic [SHW-1:0]    CNT_ZERO = {SHW{1'b0}};

    // Two's-complement negation of an XLEN-wide value.
    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return ZERO_X - v;
    endfunction

    // Two's-complement negation of a 2*XLEN-wide value.
    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
        return ZERO_2X - v;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    state_t             accept_nxt_s;
    logic               in_ready_s;
    logic               accept_s;

    logic [SHW-1:0]     cnt_r;
    logic [2*XLEN-1:0]  acc_r;
    logic [XLEN-1:0]    opb_r;
    logic               neg_r;
    logic               sel_hi_r;
    logic               is_div_r;
    logic [XLEN-1:0]    result_r;
    logic               out_valid_r;
    logic               busy_r;

    logic               signed1_s;
    logic               signed2_s;
    logic               n1_s;
    logic               n2_s;
    logic [XLEN-1:0]    mag1_s;
    logic [XLEN-1:0]    mag2_s;
    logic               neg_s;
    logic               sel_hi_s;
    logic               div_zero_s;
    logic               div_ovf_s;
    logic               fast_s;
    logic [XLEN-1:0]    fast_res_s;
    logic [XLEN-1:0]    base_res_s;

    logic [XLEN:0]      mul_add_s;
    logic [2*XLEN-1:0]  mul_step_s;
    logic [XLEN:0]      rem_sh_s;
    logic [XLEN:0]      trial_s;
    logic [2*XLEN-1:0]  div_step_s;
    logic [2*XLEN-1:0]  mul_fix_s;
    logic [XLEN-1:0]    div_half_s;
    logic [XLEN-1:0]    fix_res_s;

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign busy      = busy_r;

    // Handshake: accept in IDLE, or in DONE while the current result retires.
    always_comb begin
        in_ready_s = 1'b0;
        if (flush) begin
            in_ready_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            in_ready_s = 1'b1;
        end else if (state_r == ST_DONE && out_ready) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = in_valid && in_ready_s;
    end

    // Operand signedness, magnitudes, result sign and divide fast-path detection.
    always_comb begin
        signed1_s = 1'b0;
        signed2_s = 1'b0;
        case (funct)
            3'b001:         begin signed1_s = 1'b1; signed2_s = 1'b1; end
            3'b010:         begin signed1_s = 1'b1; signed2_s = 1'b0; end
            3'b100, 3'b110: begin signed1_s = 1'b1; signed2_s = 1'b1; end
            default:        begin signed1_s = 1'b0; signed2_s = 1'b0; end
        endcase
        n1_s   = signed1_s && op1[XLEN-1];
        n2_s   = signed2_s && op2[XLEN-1];
        mag1_s = n1_s ? neg_x(op1) : op1;
        mag2_s = n2_s ? neg_x(op2) : op2;
        // Remainder takes the dividend's sign; everything else the product sign.
        if (funct[2] && funct[1]) begin
            neg_s = n1_s;
        end else begin
            neg_s = n1_s ^ n2_s;
        end
        if (funct[2]) begin
            sel_hi_s = funct[1];
        end else begin
            sel_hi_s = (funct[1:0] != 2'b00);
        end
        div_zero_s = (op2 == ZERO_X);
        div_ovf_s  = !funct[0] && (op1 == MIN_X) && (op2 == ONES_X);
        fast_s     = funct[2] && (div_zero_s || div_ovf_s);
        if (div_zero_s) begin
            fast_res_s = funct[1] ? op1 : ONES_X;
        end else begin
            fast_res_s = funct[1] ? ZERO_X : MIN_X;
        end
    end

    // Single-cycle base operation result.
    always_comb begin
        base_res_s = ZERO_X;
        case (alu_cntl)
            4'b0000: base_res_s = op1 & op2;
            4'b0001: base_res_s = op1 | op2;
            4'b0010: base_res_s = op1 ^ op2;
            4'b0011: base_res_s = op1 << op2[SHW-1:0];
            4'b0100: base_res_s = op1 >> op2[SHW-1:0];
            4'b0101: base_res_s = $unsigned($signed(op1) >>> op2[SHW-1:0]);
            4'b0110: base_res_s = op1 + op2;
            4'b0111: begin
                case (funct)
                    3'b010:  base_res_s = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
                    3'b011:  base_res_s = {{(XLEN-1){1'b0}}, (op1 < op2)};
                    default: base_res_s = op1 - op2;
                endcase
            end
            default: base_res_s = ZERO_X;
        endcase
    end

    // One radix-2 step of shift-add multiply and of restoring divide, plus FIX.
    always_comb begin
        // Multiply: acc = {partial product high, remaining multiplier bits}.
        mul_add_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
        mul_step_s = {mul_add_s, acc_r[XLEN-1:1]};
        // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
        rem_sh_s   = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        trial_s    = rem_sh_s - {1'b0, opb_r};
        if (!trial_s[XLEN]) begin
            div_step_s = {trial_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
        end else begin
            div_step_s = {rem_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
        end
        // Multiply signs the full product before picking a half; divide signs the half.
        mul_fix_s  = neg_r ? neg_2x(acc_r) : acc_r;
        div_half_s = sel_hi_r ? acc_r[2*XLEN-1:XLEN] : acc_r[XLEN-1:0];
        if (is_div_r) begin
            fix_res_s = neg_r ? neg_x(div_half_s) : div_half_s;
        end else begin
            fix_res_s = sel_hi_r ? mul_fix_s[2*XLEN-1:XLEN] : mul_fix_s[XLEN-1:0];
        end
    end

    // Destination state for an accepted operation.
    always_comb begin
        accept_nxt_s = ST_DONE;
        if (!mext || fast_s) begin
            accept_nxt_s = ST_DONE;
        end else if (funct[2]) begin
            accept_nxt_s = ST_DIV;
        end else begin
            accept_nxt_s = ST_MUL;
        end
    end

    // FSM next-state; flush overrides retirement and iteration.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = accept_s ? accept_nxt_s : ST_IDLE;
                ST_MUL:  state_nxt_s = (cnt_r == CNT_ZERO) ? ST_FIX : ST_MUL;
                ST_DIV:  state_nxt_s = (cnt_r == CNT_ZERO) ? ST_FIX : ST_DIV;
                ST_FIX:  state_nxt_s = ST_DONE;
                ST_DONE: begin
                    if (!out_ready) begin
                        state_nxt_s = ST_DONE;
                    end else if (accept_s) begin
                        state_nxt_s = accept_nxt_s;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register with registered out_valid/busy decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s == ST_DONE);
            busy_r      <= (state_nxt_s == ST_MUL) || (state_nxt_s == ST_DIV) ||
                           (state_nxt_s == ST_FIX);
        end
    end

    // Datapath: capture on accept, iterate in MUL/DIV, write result in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= CNT_ZERO;
            acc_r    <= ZERO_2X;
            opb_r    <= ZERO_X;
            neg_r    <= 1'b0;
            sel_hi_r <= 1'b0;
            is_div_r <= 1'b0;
            result_r <= ZERO_X;
        end else if (accept_s) begin
            if (mext && !fast_s) begin
                cnt_r    <= CNT_TOP;
                neg_r    <= neg_s;
                sel_hi_r <= sel_hi_s;
                is_div_r <= funct[2];
                if (funct[2]) begin
                    acc_r <= {ZERO_X, mag1_s};
                    opb_r <= mag2_s;
                end else begin
                    acc_r <= {ZERO_X, mag2_s};
                    opb_r <= mag1_s;
                end
            end else begin
                result_r <= mext ? fast_res_s : base_res_s;
            end
        end else if (!flush) begin
            case (state_r)
                ST_MUL: begin
                    acc_r <= mul_step_s;
                    cnt_r <= cnt_r - CNT_ONE;
                end
                ST_DIV: begin
                    acc_r <= div_step_s;
                    cnt_r <= cnt_r - CNT_ONE;
                end
                ST_FIX:  result_r <= fix_res_s;
                default: cnt_r    <= cnt_r;
            endcase
        end
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised, sequential successor to the core's combinational execute-stage ALU.
- Keeps the base integer operation set and encoding.
- Adds the RV32M multiply/divide family, implemented iteratively.
- Wraps everything in valid/ready handshakes so the pipeline stalls on multi-cycle ops and can flush an in-flight op on branch redirect.

Parameters:
XLEN, 32, operand/result width (>= 8, power of two)
SHW, $clog2(XLEN), shift-amount width, derived; not overridden

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort of any accepted or in-flight op
in_valid  in  1  operation presented
in_ready  out  1  block can accept operation this cycle
mext  in  1  1 = M-extension op selected by funct; 0 = base op selected by alu_cntl
funct  in  3  instruction funct3
alu_cntl  in  4  base op code
op1  in  XLEN  operand 1 (rs1)
op2  in  XLEN  operand 2 (rs2/imm)
out_valid  out  1  result valid
out_ready  in  1  consumer takes result
result  out  XLEN  registered result
busy  out  1  high while iterating (MUL/DIV/FIX states)

Behaviour:
- Reset: async on rst_n low. State=IDLE; out_valid=0, result=0, busy=0; counter and datapath registers=0. in_ready=1 once out of reset.
- Accept: transfer when in_valid && in_ready; operands, funct, alu_cntl and mext are captured that cycle (cycle T).
- Base ops (mext=0), alu_cntl encoding:
  - 0000 AND; 0001 OR; 0010 XOR.
  - 0011 SLL; 0100 SRL; 0101 SRA. Shift amount = op2[SHW-1:0] only.
  - 0110 ADD.
  - 0111 SUB: funct=010 gives SLT (signed, true compare incl. overflow) = {0..,1}/0; funct=011 gives SLTU; other funct gives op1-op2.
  - Any other code gives result 0 (never X).
  - Latency: out_valid at T+1.
- M ops (mext=1), funct:
  - 000 MUL low; 001 MULH s*s; 010 MULHSU s*u; 011 MULHU u*u.
  - 100 DIV; 101 DIVU; 110 REM; 111 REMU.
- M-op datapath:
  - Operands converted to magnitudes per signedness at accept.
  - Radix-2 shift-add multiply into 2*XLEN product, or restoring divide: XLEN iteration cycles, 1 per cycle.
  - Then FIX cycle applies sign negation and selects high/low half.
  - Latency: out_valid at T+XLEN+2 (34 for XLEN=32).
- Divide fast paths, no iteration, out_valid at T+1:
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give op1.
  - Signed overflow (op1=MIN, op2=-1): DIV gives MIN; REM gives 0.
- States: IDLE, MUL, DIV, FIX, DONE.
  - IDLE: accept base op or fast path to DONE; MUL op to MUL; DIV op to DIV.
  - MUL/DIV: counter counts XLEN-1 down to 0; at 0 go to FIX.
  - FIX: go to DONE.
  - DONE: out_valid=1; result held stable until out_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready). A new op may be accepted in the same cycle a result retires, giving base-op throughput of 1/cycle.
- DONE && out_ready with no new accept: go to IDLE and drop out_valid next cycle.
- busy=1 exactly in MUL, DIV and FIX.
- flush:
  - Next state IDLE; out_valid=0 next cycle; pending result discarded; result register keeps its old value.
  - An in_valid in the same cycle as flush is not accepted: in_ready is forced 0 while flush is high.
  - flush has priority over out_ready and over iteration.
- Reset mid-iteration: immediate IDLE; no partial result emitted.
- Backpressure: out_valid stays asserted and result stays stable across any number of out_ready=0 cycles.

Test Plan:
- Base ops, XLEN=32, out_ready=1:
  - ADD 0xFFFFFFFF+1 -> 0x00000000 at T+1.
  - SRA 0x80000000 by op2=0x21 (shamt 1) -> 0xC0000000.
  - SLT -1<1 -> 1; SLTU 0xFFFFFFFF<1 -> 0.
  - Undefined alu_cntl 1111 -> 0.
- Back-to-back: 4 ADDs on consecutive cycles, out_ready=1 -> in_ready never drops; 4 results on consecutive cycles.
- Multiply:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF.
  - MUL 7*-3 -> 0xFFFFFFEB.
  - Each: out_valid exactly at T+34; busy high T+1..T+33.
- Divide:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14.
  - DIV x/0 -> 0xFFFFFFFF at T+1; REMU 5/0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
- Backpressure: hold out_ready=0 for 5 cycles after a MUL completes -> out_valid and result stable, in_ready=0; out_ready=1 -> retire; IDLE next cycle.
- Abort:
  - flush at T+10 of a DIV -> out_valid never rises; in_ready=1 at T+11.
  - rst_n low at T+5 of a MUL -> out_valid=0, busy=0, result=0 immediately.
